// File: rtl/word_byte_sequencer_pkg.sv
// Shared constants and helpers for the word-to-byte sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package word_byte_sequencer_pkg;

  localparam int BYTE_W = 8;

  // FSM state encoding
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SEND = 1'b1;

  // in_len code that stands for a full four-byte word
  localparam logic [1:0] LEN_FULL = 2'b00;

  // Map the 2-bit length code to a byte count of 1..4
  function automatic logic [2:0] decode_len(input logic [1:0] len);
    return (len == LEN_FULL) ? 3'd4 : {1'b0, len};
  endfunction

endpackage

// File: rtl/word_byte_sequencer_splitter.sv
// Splits a 32-bit word into four bytes, o1 = most significant.
// Latency: purely combinational.
// Backpressure: none, no state.
module splitter
  import word_byte_sequencer_pkg::*;
(
  input  logic [4*BYTE_W-1:0] a,
  output logic [BYTE_W-1:0]   o1,
  output logic [BYTE_W-1:0]   o2,
  output logic [BYTE_W-1:0]   o3,
  output logic [BYTE_W-1:0]   o4
);

  assign o1 = a[4*BYTE_W-1:3*BYTE_W];
  assign o2 = a[3*BYTE_W-1:2*BYTE_W];
  assign o3 = a[2*BYTE_W-1:BYTE_W];
  assign o4 = a[BYTE_W-1:0];

endmodule

// File: rtl/word_byte_sequencer.sv
// Serializes 1..4-byte words into a byte stream, counting completed words.
// Latency: word accepted at edge N gives its first byte in cycle N+1; L bytes take L cycles.
// Backpressure: out_ready low freezes the current byte; in_ready reopens on the last byte's handshake.
module word_byte_sequencer
  import word_byte_sequencer_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         in_word,
  input  logic [1:0]          in_len,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [BYTE_W-1:0]   out_byte,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready,
  output logic                busy,
  output logic [CNT_W-1:0]    words_done
);

  logic              state;
  logic              state_nxt;
  logic [31:0]       hold_word;
  logic [2:0]        hold_len;
  logic [1:0]        idx;
  logic [1:0]        sel_idx;
  logic [BYTE_W-1:0] b1, b2, b3, b4;
  logic [BYTE_W-1:0] sel_byte;
  logic              in_hs;
  logic              out_hs;

  splitter u_splitter (
    .a  (hold_word),
    .o1 (b1),
    .o2 (b2),
    .o3 (b3),
    .o4 (b4)
  );

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  // Byte order: reverse the index when sending least-significant first
  always_comb begin
    sel_idx  = MSB_FIRST ? idx : (2'd3 - idx);
    sel_byte = b1;
    case (sel_idx)
      2'd0:    sel_byte = b1;
      2'd1:    sel_byte = b2;
      2'd2:    sel_byte = b3;
      default: sel_byte = b4;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state: a last-byte handshake either reloads (in_valid high) or idles
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_hs) state_nxt = ST_SEND;
      default: if (out_hs && out_last) state_nxt = in_valid ? ST_SEND : ST_IDLE;
    endcase
  end

  // Outputs; in_ready is the only path combinational from out_ready
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_byte  = '0;
    busy      = 1'b0;
    in_ready  = 1'b0;
    if (state == ST_SEND) begin
      out_valid = 1'b1;
      busy      = 1'b1;
      out_byte  = sel_byte;
      out_last  = ({1'b0, idx} == (hold_len - 3'd1));
      in_ready  = out_ready & out_last;
    end else begin
      in_ready  = 1'b1;
    end
  end

  // Held word, length and byte index; a new word always restarts at index 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_word <= '0;
      hold_len  <= '0;
      idx       <= '0;
    end else if (in_hs) begin
      hold_word <= in_word;
      hold_len  <= decode_len(in_len);
      idx       <= '0;
    end else if (out_hs) begin
      idx       <= out_last ? 2'd0 : (idx + 2'd1);
    end
  end

  // Completed-word counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 words_done <= '0;
    else if (out_hs && out_last) words_done <= words_done + CNT_W'(1);
  end

endmodule
